id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Decode-to-execute boundary directly downstream of the register file. Each cycle it captures the decoded instruction fields, the control bundle and the two register-file read values into the ID/EX pipeline register. It also detects load-use hazards against the instruction currently in EX, stalls the front end and inserts bubbles, and honours a flush from branch resolution. A saturating counter tracks inserted bubbles for performance debug.

Parameters:
XLEN, 64, datapath width of PC, immediate and register data
RW, 5, register index width
BCW, 16, bubble counter width

Ports:
clk  in  1  pipeline clock, all state updates on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
id_valid  in  1  IF/ID holds a real instruction
id_pc  in  XLEN  PC of decoding instruction
id_rs1  in  RW  source 1 index (also drives register file RS1)
id_rs2  in  RW  source 2 index (also drives register file RS2)
id_rd  in  RW  destination index
id_use_rs1  in  1  instruction actually reads rs1
id_use_rs2  in  1  instruction actually reads rs2
id_imm  in  XLEN  sign-extended immediate
id_funct4  in  4  {instr[30], funct3} for ALU control
id_ctrl  in  8  {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
ReadData1  in  XLEN  register file read port 1
ReadData2  in  XLEN  register file read port 2
flush  in  1  kill instruction entering EX (taken branch)
stall_out  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX stage holds a real instruction
ex_pc, ex_imm, ex_data1, ex_data2  out  XLEN each  registered id_pc, id_imm, ReadData1, ReadData2
ex_rs1, ex_rs2, ex_rd  out  RW each  registered indices
ex_funct4  out  4  registered id_funct4
ex_ctrl  out  8  registered control bundle, same bit order as id_ctrl
bubble_count  out  BCW  bubbles inserted since reset, saturating

Behaviour:
- Reset (reset=0, asynchronous): every ex_* output, ex_valid and bubble_count go to 0. stall_out is therefore 0. This holds mid-operation and takes effect without a clock edge.
- hazard = id_valid & ex_valid & ex_ctrl[6] (MemRead) & (ex_rd != 0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall_out = hazard & ~flush. It is combinational from the registered EX state and the ID inputs, with no inputs-to-output path from ReadData.
- Posedge update, in priority order:
  1. flush=1: bubble. ex_valid=0 and every ex_* field=0. bubble_count increments if id_valid=1.
  2. stall_out=1: bubble, same zeroing. bubble_count increments.
  3. Otherwise: capture all id_* fields and ReadData1/2. ex_valid<=id_valid. ex_ctrl<=id_valid ? id_ctrl : 0, so no control bits leak from invalid slots.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ex_valid=0 and the hazard clears. The stalled instruction, still held in IF/ID by the front end, is captured on the next edge.
- A load with rd=x0 never stalls. A store (MemRead=0) never stalls. Unused sources (id_use_*=0) never stall.
- flush and hazard in the same cycle: flush wins, stall_out=0, and a single bubble is counted.
- The register file writes on negedge, so ReadData reflects same-cycle writeback by the capturing posedge. No internal bypass is required.
- bubble_count saturates at 2^BCW-1 and never wraps.

Test Plan:
- Reset: assert reset=0 with garbage on inputs, then check all ex_* = 0, ex_valid=0, stall_out=0 and bubble_count=0 without a clock edge. Release the reset; values stay 0 until the first capture.
- Pass-through: id_valid=1, id_pc=0x100, id_rd=7, ReadData1=0xAAAA, id_ctrl=0x81. After 1 edge, expect ex_pc=0x100, ex_rd=7, ex_data1=0xAAAA, ex_ctrl=0x81, ex_valid=1.
- Load-use: capture ld x5 (ctrl MemRead=1, rd=5), then present add with rs1=5 and id_use_rs1=1. Expect stall_out=1. After the next edge, expect ex_valid=0, ex_ctrl=0, bubble_count=1 and stall_out=0. After one more edge, expect the add in EX.
- No false stall: ld x0 followed by a use of rs1=0 gives stall_out=0. ld x5 followed by an instruction with rs2=5 but id_use_rs2=0 gives stall_out=0.
- Flush priority: set up a hazard and raise flush=1 in the same cycle. Expect stall_out=0, a bubble on the edge, and bubble_count incremented by exactly 1.
- Saturation: with BCW=4, force 20 consecutive flushes with id_valid=1. Expect bubble_count to stick at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// flush handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RW   = 5,
  parameter int BCW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_funct4,
  input  logic [7:0]      id_ctrl,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic            flush,
  output logic            stall_out,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_data2,
  output logic [RW-1:0]   ex_rs1,
  output logic [RW-1:0]   ex_rs2,
  output logic [RW-1:0]   ex_rd,
  output logic [3:0]      ex_funct4,
  output logic [7:0]      ex_ctrl,
  output logic [BCW-1:0]  bubble_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [3:0]      funct4;
    logic [7:0]      ctrl;
  } id_ex_t;

  id_ex_t         r_ex;
  logic [BCW-1:0] r_bubbles;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hazard;
  logic w_bubble;
  logic w_count;

  assign w_rs1_hit = id_use_rs1 && (id_rs1 == r_ex.rd);
  assign w_rs2_hit = id_use_rs2 && (id_rs2 == r_ex.rd);

  // EX holds a load whose result the ID instruction needs
  assign w_hazard = id_valid && r_ex.valid && r_ex.ctrl[6]
                 && (r_ex.rd != '0)
                 && (w_rs1_hit || w_rs2_hit);

  assign stall_out = w_hazard && !flush;
  assign w_bubble  = flush || stall_out;
  assign w_count   = flush ? id_valid : stall_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex      <= '0;
      r_bubbles <= '0;
    end else begin
      if (w_bubble) begin
        r_ex <= '0;
      end else begin
        r_ex.valid  <= id_valid;
        r_ex.pc     <= id_pc;
        r_ex.imm    <= id_imm;
        r_ex.data1  <= ReadData1;
        r_ex.data2  <= ReadData2;
        r_ex.rs1    <= id_rs1;
        r_ex.rs2    <= id_rs2;
        r_ex.rd     <= id_rd;
        r_ex.funct4 <= id_funct4;
        r_ex.ctrl   <= id_valid ? id_ctrl : 8'h00;
      end
      if (w_count && (r_bubbles != '1)) begin
        r_bubbles <= r_bubbles + 1'b1;
      end
    end
  end

  assign ex_valid     = r_ex.valid;
  assign ex_pc        = r_ex.pc;
  assign ex_imm       = r_ex.imm;
  assign ex_data1     = r_ex.data1;
  assign ex_data2     = r_ex.data2;
  assign ex_rs1       = r_ex.rs1;
  assign ex_rs2       = r_ex.rs2;
  assign ex_rd        = r_ex.rd;
  assign ex_funct4    = r_ex.funct4;
  assign ex_ctrl      = r_ex.ctrl;
  assign bubble_count = r_bubbles;

endmodule
